// File: rtl/alu_sequencer.sv
// Request-to-ALU sequencer: decodes one opcode at a time into one-hot ALU strobes,
// sequences shifts as load + N single-bit steps, and holds the result for a consumer.
module alu_sequencer #(
  parameter int DATA_WIDTH  = 8,
  parameter int SHAMT_WIDTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [3:0]             req_op,
  input  logic [DATA_WIDTH-1:0]  req_a,
  input  logic [DATA_WIDTH-1:0]  req_b,
  input  logic [SHAMT_WIDTH-1:0] req_shamt,
  output logic [DATA_WIDTH-1:0]  alu_in1,
  output logic [DATA_WIDTH-1:0]  alu_in2,
  output logic                   alu_add,
  output logic                   alu_sub,
  output logic                   alu_lsr,
  output logic                   alu_lsh,
  output logic                   alu_rsh,
  output logic                   alu_and,
  output logic                   alu_or,
  output logic                   alu_xor,
  output logic                   alu_inv,
  output logic                   alu_clr,
  input  logic [DATA_WIDTH-1:0]  alu_out,
  input  logic                   alu_overflow,
  input  logic                   alu_shiftflag,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [DATA_WIDTH-1:0]  res_data,
  output logic                   res_ovf,
  output logic                   res_err,
  output logic [7:0]             op_count
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] EXEC  = 3'd1;
  localparam logic [2:0] LOAD  = 3'd2;
  localparam logic [2:0] SHIFT = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_INV = 4'd5;
  localparam logic [3:0] OP_CLR = 4'd6;
  localparam logic [3:0] OP_LSH = 4'd7;
  localparam logic [3:0] OP_RSH = 4'd8;

  // Strobe vector bit order: add, sub, lsr, lsh, rsh, and, or, xor, inv, clr
  logic [2:0]             state, state_nxt;
  logic [3:0]             op_q, op_nxt;
  logic [SHAMT_WIDTH-1:0] shamt_q, cnt_q;
  logic                   sticky_q;
  logic [9:0]             strb_q, strb_nxt;
  logic                   accept;

  assign accept    = (state == IDLE) && req_valid;
  assign req_ready = (state == IDLE);
  assign res_valid = (state == DONE);

  assign alu_add = strb_q[0];
  assign alu_sub = strb_q[1];
  assign alu_lsr = strb_q[2];
  assign alu_lsh = strb_q[3];
  assign alu_rsh = strb_q[4];
  assign alu_and = strb_q[5];
  assign alu_or  = strb_q[6];
  assign alu_xor = strb_q[7];
  assign alu_inv = strb_q[8];
  assign alu_clr = strb_q[9];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req_valid) begin
        if (req_op > OP_RSH)
          state_nxt = DONE;
        else if (req_op >= OP_LSH && req_shamt != '0)
          state_nxt = LOAD;
        else
          state_nxt = EXEC;
      end
      EXEC:  state_nxt = DONE;
      LOAD:  state_nxt = SHIFT;
      SHIFT: if (cnt_q == SHAMT_WIDTH'(1)) state_nxt = DONE;
      DONE:  if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes are decoded from the next state so they are registered yet line up with it
  always_comb begin
    op_nxt   = accept ? req_op : op_q;
    strb_nxt = '0;
    case (state_nxt)
      EXEC: case (op_nxt)
        OP_ADD: strb_nxt[0] = 1'b1;
        OP_SUB: strb_nxt[1] = 1'b1;
        OP_AND: strb_nxt[5] = 1'b1;
        OP_OR:  strb_nxt[6] = 1'b1;
        OP_XOR: strb_nxt[7] = 1'b1;
        OP_INV: strb_nxt[8] = 1'b1;
        OP_CLR: strb_nxt[9] = 1'b1;
        default: strb_nxt = '0;
      endcase
      LOAD:  strb_nxt[2] = 1'b1;
      SHIFT: if (op_nxt == OP_LSH) strb_nxt[3] = 1'b1;
             else                  strb_nxt[4] = 1'b1;
      default: strb_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      op_q     <= '0;
      shamt_q  <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
      strb_q   <= '0;
      alu_in1  <= '0;
      alu_in2  <= '0;
      res_data <= '0;
      res_ovf  <= 1'b0;
      res_err  <= 1'b0;
      op_count <= '0;
    end else begin
      state  <= state_nxt;
      strb_q <= strb_nxt;
      op_q   <= op_nxt;
      case (state)
        IDLE: if (req_valid) begin
          alu_in1 <= req_a;
          alu_in2 <= req_b;
          shamt_q <= req_shamt;
          if (req_op > OP_RSH) begin
            res_data <= '0;
            res_ovf  <= 1'b0;
            res_err  <= 1'b1;
          end else begin
            res_err  <= 1'b0;
          end
        end
        EXEC: begin
          if (op_q <= OP_CLR) begin
            res_data <= alu_out;
            res_ovf  <= (op_q == OP_ADD || op_q == OP_SUB) ? alu_overflow : 1'b0;
          end else begin
            res_data <= {{(DATA_WIDTH-4){1'b0}}, alu_in1[3:0]};
            res_ovf  <= 1'b0;
          end
        end
        LOAD: begin
          cnt_q    <= shamt_q;
          sticky_q <= 1'b0;
        end
        SHIFT: begin
          cnt_q    <= cnt_q - SHAMT_WIDTH'(1);
          sticky_q <= sticky_q | alu_shiftflag;
          if (cnt_q == SHAMT_WIDTH'(1)) begin
            res_data <= {{(DATA_WIDTH-4){1'b0}}, alu_out[3:0]};
            res_ovf  <= sticky_q | alu_shiftflag;
          end
        end
        DONE: if (res_ready) op_count <= op_count + 8'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: a behavioural ALU (4-bit shift register for LSH/RSH) closes the loop;
// table-driven vectors plus directed sequences for hold, wrap and mid-shift reset.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [3:0] req_op = '0;
  logic [7:0] req_a = '0, req_b = '0;
  logic [1:0] req_shamt = '0;
  logic [7:0] alu_in1, alu_in2;
  logic alu_add, alu_sub, alu_lsr, alu_lsh, alu_rsh, alu_and, alu_or, alu_xor, alu_inv, alu_clr;
  logic [7:0] alu_out;
  logic       alu_overflow, alu_shiftflag;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [7:0] res_data;
  logic       res_ovf, res_err;
  logic [7:0] op_count;

  always #5 clk = ~clk;

  alu_sequencer #(.DATA_WIDTH(8), .SHAMT_WIDTH(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_shamt(req_shamt),
    .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_add(alu_add), .alu_sub(alu_sub), .alu_lsr(alu_lsr), .alu_lsh(alu_lsh),
    .alu_rsh(alu_rsh), .alu_and(alu_and), .alu_or(alu_or), .alu_xor(alu_xor),
    .alu_inv(alu_inv), .alu_clr(alu_clr),
    .alu_out(alu_out), .alu_overflow(alu_overflow), .alu_shiftflag(alu_shiftflag),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_ovf(res_ovf), .res_err(res_err), .op_count(op_count)
  );

  // Behavioural ALU: combinational ops, shifts operate on a 4-bit register loaded by lsr
  logic [3:0] sreg;
  logic [8:0] wide;
  always_comb begin
    alu_out = '0; alu_overflow = 1'b0; alu_shiftflag = 1'b0; wide = '0;
    if (alu_add) begin
      wide = {1'b0, alu_in1} + {1'b0, alu_in2};
      alu_out = wide[7:0]; alu_overflow = wide[8];
    end else if (alu_sub) begin
      wide = {1'b0, alu_in1} - {1'b0, alu_in2};
      alu_out = wide[7:0]; alu_overflow = wide[8];
    end else if (alu_and) alu_out = alu_in1 & alu_in2;
    else if (alu_or)  alu_out = alu_in1 | alu_in2;
    else if (alu_xor) alu_out = alu_in1 ^ alu_in2;
    else if (alu_inv) alu_out = ~alu_in1;
    else if (alu_clr) alu_out = '0;
    else if (alu_lsr) alu_out = {4'h0, alu_in1[3:0]};
    else if (alu_lsh) begin alu_out = {4'h0, sreg[2:0], 1'b0}; alu_shiftflag = sreg[3]; end
    else if (alu_rsh) begin alu_out = {4'h0, 1'b0, sreg[3:1]}; alu_shiftflag = sreg[0]; end
  end
  always_ff @(posedge clk) begin
    if (alu_lsr)      sreg <= alu_in1[3:0];
    else if (alu_lsh) sreg <= {sreg[2:0], 1'b0};
    else if (alu_rsh) sreg <= {1'b0, sreg[3:1]};
  end

  int total = 0;
  int bad = 0;
  int exp_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] strobes();
    return {alu_clr, alu_inv, alu_xor, alu_or, alu_and, alu_rsh, alu_lsh, alu_lsr, alu_sub, alu_add};
  endfunction

  typedef struct {
    logic [3:0] op; logic [7:0] a; logic [7:0] b; logic [1:0] sh;
    logic [7:0] d; logic ovf; logic err; int lat; int sidx; int scnt; int lcnt;
  } vec_t;

  // Drive request, wait for res_valid, check strobes, latency and captured result; no handshake.
  task automatic issue(input vec_t v);
    int cnt[10];
    int lat;
    int tot;
    logic [9:0] s;
    for (int i = 0; i < 10; i++) cnt[i] = 0;
    chk("req_ready before issue", req_ready, 1);
    req_valid = 1'b1; req_op = v.op; req_a = v.a; req_b = v.b; req_shamt = v.sh;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    chk("req_ready after accept", req_ready, 0);
    while (!res_valid && lat < 30) begin
      s = strobes();
      if ($countones(s) > 1) chk("strobe onehot", s, 0);
      for (int i = 0; i < 10; i++) if (s[i]) cnt[i]++;
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, v.lat);
    tot = 0;
    for (int i = 0; i < 10; i++) tot += cnt[i];
    chk("main strobe cycles", cnt[v.sidx], v.scnt);
    chk("lsr cycles", cnt[2], v.lcnt);
    chk("total strobe cycles", tot, v.scnt + v.lcnt);
    chk("strobes idle in DONE", strobes(), 0);
    chk("res_data", res_data, v.d);
    chk("res_ovf", res_ovf, v.ovf);
    chk("res_err", res_err, v.err);
    chk("alu_in1 held", alu_in1, v.a);
    chk("alu_in2 held", alu_in2, v.b);
    chk("req_ready in DONE", req_ready, 0);
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    exp_cnt = (exp_cnt + 1) % 256;
    chk("op_count", op_count, exp_cnt);
    chk("res_valid after handshake", res_valid, 0);
    chk("req_ready after handshake", req_ready, 1);
  endtask

  vec_t vt[16];
  vec_t add_v;
  vec_t xor_v;
  logic [7:0] hd;
  logic ho;

  initial begin
    //            op     a      b      sh    data   ovf   err  lat sidx cnt lsr
    vt[0]  = '{4'd0,  8'hF0, 8'h20, 2'd0, 8'h10, 1'b1, 1'b0, 2, 0, 1, 0};
    vt[1]  = '{4'd1,  8'h05, 8'h07, 2'd0, 8'hFE, 1'b1, 1'b0, 2, 1, 1, 0};
    vt[2]  = '{4'd4,  8'h0C, 8'h0A, 2'd0, 8'h06, 1'b0, 1'b0, 2, 7, 1, 0};
    vt[3]  = '{4'd2,  8'hF0, 8'h3C, 2'd0, 8'h30, 1'b0, 1'b0, 2, 5, 1, 0};
    vt[4]  = '{4'd3,  8'hF0, 8'h0C, 2'd0, 8'hFC, 1'b0, 1'b0, 2, 6, 1, 0};
    vt[5]  = '{4'd5,  8'h5A, 8'h00, 2'd0, 8'hA5, 1'b0, 1'b0, 2, 8, 1, 0};
    vt[6]  = '{4'd6,  8'hFF, 8'h11, 2'd0, 8'h00, 1'b0, 1'b0, 2, 9, 1, 0};
    vt[7]  = '{4'd7,  8'h09, 8'h00, 2'd3, 8'h08, 1'b1, 1'b0, 5, 3, 3, 1};
    vt[8]  = '{4'd8,  8'h3C, 8'h00, 2'd0, 8'h0C, 1'b0, 1'b0, 2, 4, 0, 0};
    vt[9]  = '{4'd12, 8'h77, 8'h66, 2'd0, 8'h00, 1'b0, 1'b1, 1, 0, 0, 0};
    vt[10] = '{4'd0,  8'h01, 8'h02, 2'd0, 8'h03, 1'b0, 1'b0, 2, 0, 1, 0};
    vt[11] = '{4'd8,  8'h06, 8'h00, 2'd1, 8'h03, 1'b0, 1'b0, 3, 4, 1, 1};
    vt[12] = '{4'd8,  8'h0B, 8'h00, 2'd2, 8'h02, 1'b1, 1'b0, 4, 4, 2, 1};
    vt[13] = '{4'd7,  8'hF1, 8'h00, 2'd2, 8'h04, 1'b0, 1'b0, 4, 3, 2, 1};
    vt[14] = '{4'd15, 8'h12, 8'h34, 2'd1, 8'h00, 1'b0, 1'b1, 1, 0, 0, 0};
    vt[15] = '{4'd1,  8'h07, 8'h05, 2'd0, 8'h02, 1'b0, 1'b0, 2, 1, 1, 0};
    add_v = vt[0];
    xor_v = vt[2];

    // Reset state
    #2;
    chk("strobes in reset", strobes(), 0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    chk("reset req_ready", req_ready, 1);
    chk("reset res_valid", res_valid, 0);
    chk("reset res_data", res_data, 0);
    chk("reset res_ovf", res_ovf, 0);
    chk("reset res_err", res_err, 0);
    chk("reset op_count", op_count, 0);
    chk("reset alu_in1", alu_in1, 0);
    chk("reset alu_in2", alu_in2, 0);

    for (int i = 0; i < 16; i++) begin
      issue(vt[i]);
      handshake();
    end

    // Hold result for 10 cycles with a competing request that must be ignored
    issue(xor_v);
    hd = res_data; ho = res_ovf;
    req_valid = 1'b1; req_op = 4'd0; req_a = 8'hAA; req_b = 8'h55; req_shamt = 2'd0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("hold res_valid", res_valid, 1);
      chk("hold res_data", res_data, hd);
      chk("hold res_ovf", res_ovf, ho);
      chk("hold req_ready", req_ready, 0);
      chk("hold alu_in1", alu_in1, xor_v.a);
    end
    req_valid = 1'b0;
    handshake();
    @(posedge clk); #1;
    chk("no queued request", res_valid, 0);
    chk("no queued request ready", req_ready, 1);

    // res_ready while idle must not count
    res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    res_ready = 1'b0;
    chk("idle res_ready op_count", op_count, exp_cnt);
    chk("idle res_ready res_valid", res_valid, 0);

    // 256 back-to-back ADDs wrap op_count back to its starting value
    hd = op_count;
    for (int i = 0; i < 256; i++) begin
      issue(add_v);
      handshake();
    end
    chk("op_count wrap", op_count, hd);

    // Reset during second SHIFT cycle of LSH shamt=3
    req_valid = 1'b1; req_op = 4'd7; req_a = 8'h09; req_b = 8'h00; req_shamt = 2'd3;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("abort LOAD lsr", alu_lsr, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("abort SHIFT2 lsh", alu_lsh, 1);
    reset = 1'b1;
    #1;
    chk("abort strobes", strobes(), 0);
    chk("abort res_valid", res_valid, 0);
    chk("abort op_count", op_count, 0);
    @(negedge clk); reset = 1'b0;
    exp_cnt = 0;
    @(posedge clk); #1;
    chk("abort res_valid after", res_valid, 0);
    issue(add_v);
    handshake();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
